// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and default addresses for the program-counter sequencer.
// The fetch unit also uses these when it checks targets of its own.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BEQ = 2'd1,
        SEL_JAL = 2'd2,
        SEL_JR  = 2'd3
    } npc_sel_e;

    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_SLOT = 1'b1
    } seq_state_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_PC     = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
    localparam int unsigned DEF_IMEM_WORDS = 32'd4096;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/target bundle between decode (master) and the PC sequencer (slave).
// The fetch-side PC outputs travel back in the same bundle.
interface pc_sequencer_if;

    logic        stall_in;
    logic        beq_req_in;
    logic [31:0] beq_target_in;
    logic        jal_req_in;
    logic [31:0] jal_target_in;
    logic        jr_req_in;
    logic [31:0] jr_target_in;
    logic        eret_req_in;
    logic [31:0] epc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [1:0]  npc_sel_out;
    logic        in_delay_slot_out;
    logic        exc_out;
    logic [31:0] fault_addr_out;
    logic        proto_err_out;

    modport master (
        output stall_in, beq_req_in, beq_target_in, jal_req_in, jal_target_in,
               jr_req_in, jr_target_in, eret_req_in, epc_in,
        input  pc_out, pc_plus4_out, npc_sel_out, in_delay_slot_out, exc_out,
               fault_addr_out, proto_err_out
    );

    modport slave (
        input  stall_in, beq_req_in, beq_target_in, jal_req_in, jal_target_in,
               jr_req_in, jr_target_in, eret_req_in, epc_in,
        output pc_out, pc_plus4_out, npc_sel_out, in_delay_slot_out, exc_out,
               fault_addr_out, proto_err_out
    );

endinterface

// File: rtl/pc_sequencer_target_check.sv
// Fetch-target legality: word aligned and inside the instruction memory window.
// The compare is done at 33 bits so a window ending at the top of the map cannot wrap.
module pc_sequencer_target_check
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
    input  logic [31:0] target,
    output logic        legal
);

    localparam logic [32:0] LOW_BOUND  = {1'b0, IMEM_BASE};
    localparam logic [32:0] HIGH_BOUND = LOW_BOUND + (33'(IMEM_WORDS) << 2);

    logic [32:0] target_wide_s;

    assign target_wide_s = {1'b0, target};
    assign legal = (target[1:0] == 2'b00) &&
                   (target_wide_s >= LOW_BOUND) &&
                   (target_wide_s <  HIGH_BOUND);

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with MIPS single delay slot, jr > jal > beq arbitration
// and eret override; illegal redirect targets vector to the exception handler.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_PC     = DEF_EXC_PC,
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);

    seq_state_e  state_r;
    logic [31:0] pc_r;
    logic [31:0] target_r;
    logic [31:0] fault_addr_r;
    logic        proto_err_r;
    logic [31:0] redirect_target_s;
    npc_sel_e    sel_s;
    logic        target_ok_s;
    logic        any_req_s;
    logic        exc_s;

    assign any_req_s = bus.beq_req_in | bus.jal_req_in | bus.jr_req_in | bus.eret_req_in;

    pc_sequencer_target_check #(
        .IMEM_BASE  (IMEM_BASE),
        .IMEM_WORDS (IMEM_WORDS)
    ) u_target_check (
        .target (target_r),
        .legal  (target_ok_s)
    );

    // Pick the delayed-redirect winner; eret and the slot cycle select nothing.
    always_comb begin
        sel_s             = SEL_SEQ;
        redirect_target_s = 32'd0;
        if ((state_r == ST_SEQ) && !bus.eret_req_in) begin
            if (bus.jr_req_in) begin
                sel_s             = SEL_JR;
                redirect_target_s = bus.jr_target_in;
            end else if (bus.jal_req_in) begin
                sel_s             = SEL_JAL;
                redirect_target_s = bus.jal_target_in;
            end else if (bus.beq_req_in) begin
                sel_s             = SEL_BEQ;
                redirect_target_s = bus.beq_target_in;
            end else begin
                sel_s             = SEL_SEQ;
                redirect_target_s = 32'd0;
            end
        end else begin
            sel_s             = SEL_SEQ;
            redirect_target_s = 32'd0;
        end
    end

    // Fault pulse marks the slot cycle whose edge vectors to the handler.
    always_comb begin
        exc_s = 1'b0;
        if ((state_r == ST_SLOT) && !target_ok_s && !bus.stall_in) begin
            exc_s = 1'b1;
        end else begin
            exc_s = 1'b0;
        end
    end

    // PC / delay-slot state machine; a stall freezes every register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_SEQ;
            pc_r         <= RESET_PC;
            target_r     <= 32'd0;
            fault_addr_r <= 32'd0;
            proto_err_r  <= 1'b0;
        end else if (!bus.stall_in) begin
            case (state_r)
                ST_SEQ: begin
                    if (bus.eret_req_in) begin
                        pc_r <= bus.epc_in;
                    end else if (sel_s != SEL_SEQ) begin
                        pc_r     <= pc_r + 32'd4;
                        target_r <= redirect_target_s;
                        state_r  <= ST_SLOT;
                    end else begin
                        pc_r <= pc_r + 32'd4;
                    end
                end
                ST_SLOT: begin
                    // A request here would be a branch in a delay slot: flag it, ignore it.
                    if (any_req_s) begin
                        proto_err_r <= 1'b1;
                    end
                    if (target_ok_s) begin
                        pc_r <= target_r;
                    end else begin
                        pc_r         <= EXC_PC;
                        fault_addr_r <= target_r;
                    end
                    state_r <= ST_SEQ;
                end
                default: begin
                    state_r <= ST_SEQ;
                end
            endcase
        end
    end

    assign bus.pc_out            = pc_r;
    assign bus.pc_plus4_out      = pc_r + 32'd4;
    assign bus.npc_sel_out       = sel_s;
    assign bus.in_delay_slot_out = (state_r == ST_SLOT);
    assign bus.exc_out           = exc_s;
    assign bus.fault_addr_out    = fault_addr_r;
    assign bus.proto_err_out     = proto_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// checked against a queue-based behavioural model of fetch order.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_PC     = 32'h0000_4180;
    localparam longint      IMEM_LO    = 64'h0000_3000;
    localparam longint      IMEM_BYTES = 64'd16384;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pc_sequencer_if bus();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] plus4;
        logic [31:0] fault;
        logic [1:0]  sel;
        logic        slot;
        logic        exc;
        logic        proto;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: current PC, last fault, sticky error, redirects still owed.
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_fault = 32'd0;
    logic        m_proto = 1'b0;
    logic [31:0] pend_q[$];

    function automatic bit legal(input logic [31:0] t);
        longint v;
        v = longint'(t);
        return (v % 4 == 0) && (v >= IMEM_LO) && (v < IMEM_LO + IMEM_BYTES);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, queue this cycle's expectation, advance the model.
    task automatic cycle(input bit rs, input bit st,
                         input bit b, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt,
                         input bit r, input logic [31:0] rt,
                         input bit e, input logic [31:0] ep);
        exp_t        x;
        logic [31:0] t;
        @(posedge clk);
        #1;
        reset             = rs;
        bus.stall_in      = st;
        bus.beq_req_in    = b;
        bus.beq_target_in = bt;
        bus.jal_req_in    = j;
        bus.jal_target_in = jt;
        bus.jr_req_in     = r;
        bus.jr_target_in  = rt;
        bus.eret_req_in   = e;
        bus.epc_in        = ep;
        if (rs) begin
            m_pc    = RESET_PC;
            m_fault = 32'd0;
            m_proto = 1'b0;
            pend_q.delete();
        end
        x.pc    = m_pc;
        x.plus4 = m_pc + 32'd4;
        x.fault = m_fault;
        x.proto = m_proto;
        x.slot  = (pend_q.size() != 0);
        x.sel   = 2'd0;
        if (!x.slot && !e) x.sel = r ? 2'd3 : (j ? 2'd2 : (b ? 2'd1 : 2'd0));
        x.exc   = x.slot && !st && !legal(pend_q[0]);
        exp_q.push_back(x);
        if (!rs && !st) begin
            if (x.slot) begin
                t = pend_q.pop_front();
                if (b || j || r || e) m_proto = 1'b1;
                if (legal(t)) m_pc = t;
                else begin
                    m_pc    = EXC_PC;
                    m_fault = t;
                end
            end else if (e) m_pc = ep;
            else if (r) begin pend_q.push_back(rt); m_pc = m_pc + 32'd4; end
            else if (j) begin pend_q.push_back(jt); m_pc = m_pc + 32'd4; end
            else if (b) begin pend_q.push_back(bt); m_pc = m_pc + 32'd4; end
            else m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    endtask

    task automatic rst1();
        cycle(1, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    endtask

    task automatic stall1();
        cycle(0, 1, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    endtask

    // Fixed-value spot check of pc_out in the cycle just driven.
    task automatic spot(input string name, input logic [31:0] want);
        @(negedge clk);
        #1;
        check(name, bus.pc_out, want);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] pick[4];
        pick[0] = 32'h0000_2FFC;
        pick[1] = 32'h0000_3000;
        pick[2] = 32'h0000_6FFC;
        pick[3] = 32'h0000_7000;
        case ($urandom % 8)
            0:       return 32'h0000_3000 + ($urandom % 32'h4000) | 32'd1;
            1:       return $urandom;
            2:       return pick[$urandom % 4];
            default: return 32'h0000_3000 + (($urandom % 4096) << 2);
        endcase
    endfunction

    // Monitor: every cycle the DUT presents a PC, compare it with the oldest expectation.
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("pc_out",       bus.pc_out,                    x.pc);
            check("pc_plus4_out", bus.pc_plus4_out,              x.plus4);
            check("npc_sel_out",  32'(bus.npc_sel_out),          32'(x.sel));
            check("delay_slot",   32'(bus.in_delay_slot_out),    32'(x.slot));
            check("exc_out",      32'(bus.exc_out),              32'(x.exc));
            check("fault_addr",   bus.fault_addr_out,            x.fault);
            check("proto_err",    32'(bus.proto_err_out),        32'(x.proto));
        end
    end

    initial begin
        bit rs, st, b, j, r, e;
        int cls;
        bus.stall_in = 1'b0;   bus.beq_req_in = 1'b0;  bus.beq_target_in = 32'd0;
        bus.jal_req_in = 1'b0; bus.jal_target_in = 32'd0;
        bus.jr_req_in = 1'b0;  bus.jr_target_in = 32'd0;
        bus.eret_req_in = 1'b0; bus.epc_in = 32'd0;

        rst1(); rst1();
        idle(); spot("seq0", 32'h3000);
        idle(); spot("seq1", 32'h3004);
        idle(); spot("seq2", 32'h3008);
        idle(); spot("seq3", 32'h300C);

        rst1(); idle(); idle();
        cycle(0, 0, 0, 32'd0, 1, 32'h3100, 0, 32'd0, 0, 32'd0); spot("jal_req", 32'h3008);
        idle(); spot("jal_slot", 32'h300C);
        idle(); spot("jal_tgt", 32'h3100);

        rst1();
        cycle(0, 0, 1, 32'h3040, 1, 32'h3080, 1, 32'h30C0, 0, 32'd0);
        idle(); spot("prio_slot", 32'h3004);
        idle(); spot("prio_tgt", 32'h30C0);

        rst1();
        cycle(0, 0, 0, 32'd0, 0, 32'd0, 1, 32'h3002, 0, 32'd0);
        idle(); idle(); spot("unaligned_exc", EXC_PC);
        rst1();
        cycle(0, 0, 0, 32'd0, 0, 32'd0, 1, 32'h7000, 0, 32'd0);
        idle(); idle(); spot("range_exc", EXC_PC);
        rst1();
        cycle(0, 0, 0, 32'd0, 0, 32'd0, 1, 32'h6FFC, 0, 32'd0);
        idle(); idle(); spot("top_word", 32'h6FFC);

        rst1(); idle(); idle(); idle(); idle();
        cycle(0, 0, 1, 32'h3200, 0, 32'd0, 0, 32'd0, 0, 32'd0);
        stall1(); stall1(); stall1(); spot("stall_hold", 32'h3014);
        idle(); idle(); spot("stall_tgt", 32'h3200);

        rst1();
        for (int i = 0; i < 8; i++) idle();
        cycle(0, 0, 0, 32'd0, 1, 32'h3300, 0, 32'd0, 0, 32'd0);
        rst1(); idle(); spot("reset_slot", 32'h3000);
        idle(); spot("reset_discard", 32'h3004);

        cycle(0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 1, 32'h3050);
        idle(); spot("eret", 32'h3050);

        cycle(0, 0, 1, 32'h3100, 0, 32'd0, 0, 32'd0, 0, 32'd0);
        cycle(0, 0, 1, 32'h3400, 0, 32'd0, 0, 32'd0, 0, 32'd0);
        idle(); spot("slot_branch", 32'h3100);

        cycle(0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 1, 32'hFFFF_FFFC);
        idle(); idle(); spot("wrap", 32'h0000_0000);

        for (int n = 0; n < 2000; n++) begin
            rs  = ($urandom % 100) == 0;
            st  = ($urandom % 5) == 0;
            cls = $urandom % 12;
            b = (cls == 0) || (cls == 1) || (cls == 5 && $urandom % 2 == 1);
            j = (cls == 2) || (cls == 5 && $urandom % 2 == 1);
            r = (cls == 3) || (cls == 5 && $urandom % 2 == 1);
            e = (cls == 4) || (cls == 5 && $urandom % 4 == 0);
            cycle(rs, st, b, rand_target(), j, rand_target(), r, rand_target(),
                  e, rand_target());
        end
        idle(); idle();

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences next-PC selection for the CPU datapath.
- Arbitrates simultaneous branch, jal, jr and eret redirect requests.
- Implements the MIPS one-instruction branch delay slot. Redirect targets are validated; a bad target vectors to the exception handler.
- Sits between the decode/control logic (requesters) and instruction memory (PC consumer). It replaces ad-hoc combinational next-PC chaining with a registered, stall-aware controller.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_PC, 32'h0000_4180, handler entry on target fault.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_WORDS, 4096, number of legal instruction words starting at IMEM_BASE.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall_in  in  1  hold PC and state this cycle
- beq_req_in  in  1  taken conditional branch request
- beq_target_in  in  32  branch target
- jal_req_in  in  1  jump (j/jal) request
- jal_target_in  in  32  jump target
- jr_req_in  in  1  register jump request
- jr_target_in  in  32  register target
- eret_req_in  in  1  return from exception (no delay slot)
- epc_in  in  32  return address for eret
- pc_out  out  32  current fetch PC
- pc_plus4_out  out  32  pc_out + 4 (combinational)
- npc_sel_out  out  2  winning source: 0 seq, 1 beq, 2 jal, 3 jr
- in_delay_slot_out  out  1  current pc_out is a delay-slot instruction
- exc_out  out  1  one-cycle pulse: PC is being vectored to EXC_PC
- fault_addr_out  out  32  offending target, held until next fault
- proto_err_out  out  1  sticky: redirect request received in SLOT state

Behaviour:
- Reset (async, any time, including mid-redirect):
  - pc_out=RESET_PC, state=SEQ, pending target cleared.
  - npc_sel_out=0, in_delay_slot_out=0, exc_out=0, fault_addr_out=0, proto_err_out=0.
- stall_in=1: no register changes. Requests are ignored, and requesters hold them until stall drops. exc_out is forced 0 during stall.
- Arbitration (SEQ only): jr > jal > beq. eret_req_in outranks all three. npc_sel_out reflects the winner combinationally; it is 0 when there is no request.
- Target legality:
  - target[1:0]==0, and
  - IMEM_BASE <= target < IMEM_BASE + 4*IMEM_WORDS, using 33-bit compare so the bound cannot wrap.
- States:
  - SEQ:
    - No request: pc<=pc+4, with 32-bit wrap.
    - eret: pc<=epc_in next edge, stay SEQ. epc_in is not validated.
    - beq/jal/jr winner: pc<=pc+4 (delay slot), latch winner target, go SLOT. in_delay_slot_out=1 in SLOT.
  - SLOT:
    - Legal latched target: pc<=target, go SEQ.
    - Illegal target: pc<=EXC_PC, exc_out=1 for that cycle, fault_addr_out<=target, go SEQ.
    - Any redirect or eret request here (branch in delay slot): request ignored, proto_err_out<=1, PC proceeds as above.
- Latency:
  - Redirect takes effect two fetches after the request edge: slot, then target.
  - eret takes effect on the next fetch.
- Stall in SLOT: stays in SLOT, latched target kept.

Decomposition:
- Shared package (cpu_pkg): npc_sel encodings (SEL_SEQ=0, SEL_BEQ=1, SEL_JAL=2, SEL_JR=3), state encodings (SEQ, SLOT), default RESET_PC/EXC_PC constants.
- One natural sub-module: pc_target_check (combinational alignment + range check, reused by the fetch unit).

Test Plan:
- Reset released, no requests, 4 cycles -> pc_out 0x3000, 0x3004, 0x3008, 0x300C; all flags 0.
- At pc 0x3008, jal_req with target 0x3100 -> pc 0x300C with in_delay_slot_out=1, then 0x3100; npc_sel_out=2 during request.
- At pc 0x3000, beq+jal+jr all high, targets 0x3040/0x3080/0x30C0 -> npc_sel_out=3; sequence 0x3004 then 0x30C0.
- At pc 0x3000, jr target 0x3002 -> slot 0x3004, then pc 0x4180, exc_out pulses 1 cycle, fault_addr_out=0x3002. Repeat with target 0x7000 (out of range) -> same vectoring.
- At pc 0x3010, beq to 0x3200, stall_in high 3 cycles during SLOT -> pc holds 0x3014, then 0x3200. At pc 0x3020, assert reset mid-SLOT -> pc 0x3000, state SEQ, target discarded.
- Two further checks:
  - eret with epc 0x3050 -> next pc 0x3050, no delay slot.
  - beq asserted in SLOT -> proto_err_out sticks 1; PC still reaches the first target.
